// File: rtl/leap_dice_chain_latency_monitor_pkg.sv
// Shared types for the LEAP-DICE delay-chain latency monitor: FSM state
// encoding and the accumulator sizing helper.
package leap_dice_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // The sum of 2^max_avg_log2 counts of cnt_w bits can never overflow this.
  function automatic int acc_width(input int cnt_w, input int max_avg_log2);
    return cnt_w + max_avg_log2;
  endfunction

endpackage

// File: rtl/leap_dice_chain_latency_monitor_if.sv
// Request/result bundle between a requester (master) and the latency monitor (slave).
// Handshake: start is a single-cycle request with no ready; it is taken only on an
// edge where the monitor is idle (busy=0 and done=0), otherwise it is dropped.
interface leap_dice_chain_latency_monitor_if
  import leap_dice_mon_pkg::*;
#(
  parameter int N            = 16,
  parameter int CNT_WIDTH    = 8,
  parameter int MAX_AVG_LOG2 = 3,
  parameter int TAP_W        = $clog2(N),
  parameter int AVG_W        = $clog2(MAX_AVG_LOG2 + 1)
);

  logic                 start;
  logic [TAP_W-1:0]     tap_sel;
  logic [AVG_W-1:0]     avg_log2;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] last_cnt;
  logic [CNT_WIDTH-1:0] min_cnt;
  logic [CNT_WIDTH-1:0] max_cnt;
  logic [CNT_WIDTH-1:0] avg_cnt;
  logic                 timeout;
  state_t               dbg_state;

  modport master (
    output start, tap_sel, avg_log2,
    input  busy, done, last_cnt, min_cnt, max_cnt, avg_cnt, timeout, dbg_state
  );

  modport slave (
    input  start, tap_sel, avg_log2,
    output busy, done, last_cnt, min_cnt, max_cnt, avg_cnt, timeout, dbg_state
  );

endinterface

// File: rtl/leap_dice_chain_latency_monitor_chain.sv
// LEAP-DICE storage cell and the single-token shift chain built from it.
// The chain only shifts forward; a cleared chain carries exactly one launched '1'.
module leap_dice_dff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= d;
  end

  assign q = q_q;

endmodule

module leap_dice_dff_chain #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inject,
  output logic [N-1:0] q
);

  logic [N-1:0] d;

  always_comb begin
    d = '0;
    if (!clear) begin
      d[0] = inject;
      for (int i = 1; i < N; i++) d[i] = q[i-1];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cell
    leap_dice_dff u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d[g]),
      .q     (q[g])
    );
  end

endmodule

// File: rtl/leap_dice_chain_latency_monitor.sv
// Repeats a flush/launch/measure cycle on the LEAP-DICE chain 2^avg_log2 times and
// publishes last/min/max/average edge counts plus a saturation flag on done.
module leap_dice_chain_latency_monitor
  import leap_dice_mon_pkg::*;
#(
  parameter int N            = 16,
  parameter int CNT_WIDTH    = 8,
  parameter int MAX_AVG_LOG2 = 3,
  parameter int TAP_W        = $clog2(N),
  parameter int AVG_W        = $clog2(MAX_AVG_LOG2 + 1)
) (
  input  logic clk,
  input  logic rst_n,
  leap_dice_chain_latency_monitor_if.slave mon
);

  localparam int ACC_W = acc_width(CNT_WIDTH, MAX_AVG_LOG2);
  localparam int FL_W  = (N > 1) ? $clog2(N) : 1;
  localparam int RUN_W = MAX_AVG_LOG2 + 1;
  localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(N - 1);
  localparam logic [AVG_W-1:0] AVG_MAX = AVG_W'(MAX_AVG_LOG2);
  localparam logic [FL_W-1:0]  FL_LAST = FL_W'(N - 1);

  state_t state_q, state_d;

  logic [TAP_W-1:0]     tap_q, tap_d;
  logic [AVG_W-1:0]     avg_q, avg_d;
  logic [FL_W-1:0]      flush_q, flush_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0]     runs_q, runs_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_WIDTH-1:0] min_q, min_d;
  logic [CNT_WIDTH-1:0] max_q, max_d;
  logic [CNT_WIDTH-1:0] last_q, last_d;
  logic                 to_q, to_d;

  logic [CNT_WIDTH-1:0] res_last_q, res_last_d;
  logic [CNT_WIDTH-1:0] res_min_q, res_min_d;
  logic [CNT_WIDTH-1:0] res_max_q, res_max_d;
  logic [CNT_WIDTH-1:0] res_avg_q, res_avg_d;
  logic                 res_to_q, res_to_d;

  logic [N-1:0]         chain_q;
  logic [TAP_W-1:0]     tap_clamp;
  logic [AVG_W-1:0]     avg_clamp;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [RUN_W-1:0]     runs_inc;
  logic                 hit, sat, run_end, last_run, flush_done;

  leap_dice_dff_chain #(.N(N)) u_chain (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == ST_FLUSH),
    .inject (state_q == ST_LAUNCH),
    .q      (chain_q)
  );

  assign tap_clamp  = (int'(mon.tap_sel) > N - 1) ? TAP_MAX : mon.tap_sel;
  assign avg_clamp  = (int'(mon.avg_log2) > MAX_AVG_LOG2) ? AVG_MAX : mon.avg_log2;
  assign cnt_inc    = cnt_q + CNT_WIDTH'(1);
  assign runs_inc   = runs_q + RUN_W'(1);
  assign flush_done = (flush_q == FL_LAST);
  // The run count is cnt_inc on the sampling edge; a hit wins over saturation.
  assign hit        = (state_q == ST_MEASURE) && chain_q[tap_q];
  assign sat        = (state_q == ST_MEASURE) && (cnt_inc == {CNT_WIDTH{1'b1}});
  assign run_end    = hit || sat;
  assign last_run   = (runs_inc == (RUN_W'(1) << avg_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (mon.start) state_d = ST_FLUSH;
      ST_FLUSH:   if (flush_done) state_d = ST_LAUNCH;
      ST_LAUNCH:  state_d = ST_MEASURE;
      ST_MEASURE: if (run_end) state_d = last_run ? ST_DONE : ST_FLUSH;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mon.busy      = (state_q == ST_FLUSH) || (state_q == ST_LAUNCH) ||
                    (state_q == ST_MEASURE);
    mon.done      = (state_q == ST_DONE);
    mon.dbg_state = state_q;
    mon.last_cnt  = res_last_q;
    mon.min_cnt   = res_min_q;
    mon.max_cnt   = res_max_q;
    mon.avg_cnt   = res_avg_q;
    mon.timeout   = res_to_q;
  end

  always_comb begin
    tap_d      = tap_q;
    avg_d      = avg_q;
    flush_d    = flush_q;
    cnt_d      = cnt_q;
    runs_d     = runs_q;
    acc_d      = acc_q;
    min_d      = min_q;
    max_d      = max_q;
    last_d     = last_q;
    to_d       = to_q;
    res_last_d = res_last_q;
    res_min_d  = res_min_q;
    res_max_d  = res_max_q;
    res_avg_d  = res_avg_q;
    res_to_d   = res_to_q;
    case (state_q)
      ST_IDLE: begin
        if (mon.start) begin
          tap_d   = tap_clamp;
          avg_d   = avg_clamp;
          flush_d = '0;
          min_d   = '1;
          max_d   = '0;
          acc_d   = '0;
          runs_d  = '0;
          to_d    = 1'b0;
        end
      end
      ST_FLUSH:  flush_d = flush_q + FL_W'(1);
      ST_LAUNCH: begin
        cnt_d   = '0;
        flush_d = '0;
      end
      ST_MEASURE: begin
        cnt_d = cnt_inc;
        if (run_end) begin
          acc_d  = acc_q + ACC_W'(cnt_inc);
          min_d  = (cnt_inc < min_q) ? cnt_inc : min_q;
          max_d  = (cnt_inc > max_q) ? cnt_inc : max_q;
          last_d = cnt_inc;
          runs_d = runs_inc;
          to_d   = to_q | ~hit;
          // Results publish on the edge entering DONE, so they use the updated values.
          if (last_run) begin
            res_last_d = cnt_inc;
            res_min_d  = min_d;
            res_max_d  = max_d;
            res_avg_d  = CNT_WIDTH'(acc_d >> avg_q);
            res_to_d   = to_d;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q      <= '0;
      avg_q      <= '0;
      flush_q    <= '0;
      cnt_q      <= '0;
      runs_q     <= '0;
      acc_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      last_q     <= '0;
      to_q       <= 1'b0;
      res_last_q <= '0;
      res_min_q  <= '0;
      res_max_q  <= '0;
      res_avg_q  <= '0;
      res_to_q   <= 1'b0;
    end else begin
      tap_q      <= tap_d;
      avg_q      <= avg_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
      runs_q     <= runs_d;
      acc_q      <= acc_d;
      min_q      <= min_d;
      max_q      <= max_d;
      last_q     <= last_d;
      to_q       <= to_d;
      res_last_q <= res_last_d;
      res_min_q  <= res_min_d;
      res_max_q  <= res_max_d;
      res_avg_q  <= res_avg_d;
      res_to_q   <= res_to_d;
    end
  end

endmodule

// File: tb/tb_leap_dice_chain_latency_monitor.sv
// Randomised bench for the chain latency monitor with a queue-based scoreboard.
// Small CNT_WIDTH/MAX_AVG_LOG2 make saturation and avg_log2 clamping reachable.
module tb_leap_dice_chain_latency_monitor;
  import leap_dice_mon_pkg::*;

  localparam int N     = 16;
  localparam int CW    = 4;
  localparam int MAXA  = 2;
  localparam int TAP_W = $clog2(N);
  localparam int AVG_W = $clog2(MAXA + 1);

  typedef struct {
    int last;
    int mn;
    int mx;
    int avg;
    int to;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   in_flight = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  leap_dice_chain_latency_monitor_if #(.N(N), .CNT_WIDTH(CW), .MAX_AVG_LOG2(MAXA)) mon ();

  leap_dice_chain_latency_monitor #(.N(N), .CNT_WIDTH(CW), .MAX_AVG_LOG2(MAXA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mon)
  );

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: every run of a healthy chain sees tap+1 edges, capped at the
  // counter's all-ones value; each run costs N flush + 1 launch + count cycles.
  function automatic exp_t model(input int tap, input int a, input int accept_cyc);
    exp_t e;
    int t, ae, runs, sat, c, sum, lat;
    t    = (tap > N - 1) ? N - 1 : tap;
    ae   = (a > MAXA) ? MAXA : a;
    runs = 1 << ae;
    sat  = (1 << CW) - 1;
    sum  = 0;
    lat  = 0;
    e.mn = sat;
    e.mx = 0;
    e.to = 0;
    for (int r = 0; r < runs; r++) begin
      c = (t + 1 <= sat) ? t + 1 : sat;
      if (t + 1 > sat) e.to = 1;
      sum += c;
      if (c < e.mn) e.mn = c;
      if (c > e.mx) e.mx = c;
      e.last = c;
      lat += N + 1 + c;
    end
    e.avg      = sum >> ae;
    e.done_cyc = accept_cyc + lat;
    return e;
  endfunction

  task automatic wait_idle();
    int i;
    for (i = 0; i < 1000 && (in_flight || mon.busy || mon.done); i++) @(negedge clk);
    if (in_flight || mon.busy || mon.done) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: monitor still busy after %0d cycles", i);
      rst_n = 1'b0;
      exp_q.delete();
      in_flight = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic issue(input int tap, input int a);
    wait_idle();
    mon.start    = 1'b1;
    mon.tap_sel  = TAP_W'(tap);
    mon.avg_log2 = AVG_W'(a);
    @(posedge clk);
    #1;
    in_flight = 1'b1;
    exp_q.push_back(model(tap, a, cyc));
    mon.start = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, int'(mon.busy), 0);
    check({tag, "_done"}, int'(mon.done), 0);
    check({tag, "_last"}, int'(mon.last_cnt), 0);
    check({tag, "_min"}, int'(mon.min_cnt), 0);
    check({tag, "_max"}, int'(mon.max_cnt), 0);
    check({tag, "_avg"}, int'(mon.avg_cnt), 0);
    check({tag, "_timeout"}, int'(mon.timeout), 0);
    check({tag, "_state"}, int'(mon.dbg_state), int'(ST_IDLE));
    check({tag, "_chain_q"}, int'(dut.u_chain.q), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mon.done) begin
        check("busy_at_done", int'(mon.busy), 0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 with no outstanding request at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("last_cnt", int'(mon.last_cnt), e.last);
          check("min_cnt", int'(mon.min_cnt), e.mn);
          check("max_cnt", int'(mon.max_cnt), e.mx);
          check("avg_cnt", int'(mon.avg_cnt), e.avg);
          check("timeout", int'(mon.timeout), e.to);
          check("done_cycle", cyc, e.done_cyc);
        end
        in_flight = 1'b0;
      end else begin
        check("busy", int'(mon.busy), int'(in_flight));
      end
    end
  end

  initial begin
    int i;
    mon.start    = 1'b0;
    mon.tap_sel  = '0;
    mon.avg_log2 = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(15, 0);  // saturates: count would be 16 > 15
    issue(14, 0);  // hit on the saturating edge: 15, no timeout
    issue(3, 2);
    issue(0, 1);
    issue(2, 3);   // avg_log2 clamps to MAXA
    issue(15, 3);

    // A second start during MEASURE must be ignored.
    issue(7, 1);
    repeat (N + 4) @(negedge clk);
    check("mid_state", int'(mon.dbg_state), int'(ST_MEASURE));
    mon.start   = 1'b1;
    mon.tap_sel = TAP_W'(2);
    @(negedge clk);
    mon.start = 1'b0;

    for (int k = 0; k < 10; k++) issue($urandom_range(0, N - 1), $urandom_range(0, 3));

    // Reset during the second run's MEASURE phase (tap 5 -> 23-cycle runs).
    issue(5, 2);
    repeat (42) @(negedge clk);
    check("run2_state", int'(mon.dbg_state), int'(ST_MEASURE));
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    in_flight = 1'b0;
    check_cleared("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(9, 1);
    issue(12, 2);

    for (i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d results still outstanding", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
